// File: rtl/scope_trigger_capture.sv
// Oscilloscope acquisition front end: edge trigger with auto/normal/single modes,
// DEPTH-sample circular capture around the trigger, frozen for display readout.
module scope_trigger_capture #(
    parameter int DW           = 16,
    parameter int AW           = 8,
    parameter int PRE          = 32,
    parameter int AUTO_TIMEOUT = 65536
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_slope,
    input  logic [1:0]    trig_mode,
    input  logic          arm,
    input  logic          frame_done,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          capture_ready,
    output logic          auto_trig,
    output logic [2:0]    state_o
);

    localparam int DEPTH = 1 << AW;
    localparam int TW    = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [DW-1:0] MID        = {1'b1, {(DW-1){1'b0}}};
    localparam logic [AW-1:0] PRE_A      = AW'(PRE);
    localparam logic [AW-1:0] PRE_LAST   = AW'(PRE - 1);
    localparam logic [AW-1:0] POST_LAST  = AW'(DEPTH - PRE - 2);
    localparam logic [TW-1:0] TMO_LAST   = TW'(AUTO_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFILL   = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] pre_cnt;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] trig_ptr;
    logic [TW-1:0] tmo_cnt;
    logic [DW-1:0] prev;
    logic          prev_valid;
    logic          writing;
    logic          edge_hit;
    logic          auto_hit;
    logic [AW-1:0] rd_phys;

    assign writing = sample_valid &&
                     (state == PREFILL || state == WAIT_TRIG || state == POST);

    always_comb begin
        edge_hit = 1'b0;
        if (prev_valid) begin
            if (!trig_slope)
                edge_hit = (prev < trig_level) && (sample >= trig_level);
            else
                edge_hit = (prev >= trig_level) && (sample < trig_level);
        end
    end

    assign auto_hit = (trig_mode == 2'd0) && (tmo_cnt == TMO_LAST);
    // Logical index 0 is the oldest pre-trigger sample, PRE slots before trig_ptr.
    assign rd_phys  = trig_ptr - PRE_A + rd_addr;
    assign state_o  = state;

    always_ff @(posedge CLOCK_50) begin
        if (writing)
            mem[wr_ptr] <= sample;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            rd_data <= MID;
        else if (state == READY)
            rd_data <= mem[rd_phys];
        else
            rd_data <= MID;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            pre_cnt       <= '0;
            post_cnt      <= '0;
            trig_ptr      <= '0;
            tmo_cnt       <= '0;
            prev          <= '0;
            prev_valid    <= 1'b0;
            capture_ready <= 1'b0;
            auto_trig     <= 1'b0;
        end else begin
            if (writing)
                wr_ptr <= wr_ptr + 1'b1;

            case (state)
                IDLE: begin
                    if (trig_mode != 2'd2 || arm) begin
                        state      <= PREFILL;
                        pre_cnt    <= '0;
                        prev_valid <= 1'b0;
                    end
                end
                PREFILL: begin
                    if (sample_valid) begin
                        prev       <= sample;
                        prev_valid <= 1'b1;
                        pre_cnt    <= pre_cnt + 1'b1;
                        if (pre_cnt == PRE_LAST) begin
                            state   <= WAIT_TRIG;
                            tmo_cnt <= '0;
                        end
                    end
                end
                WAIT_TRIG: begin
                    if (sample_valid) begin
                        prev       <= sample;
                        prev_valid <= 1'b1;
                        // A real edge wins over the timeout on the same sample.
                        if (edge_hit || auto_hit) begin
                            trig_ptr  <= wr_ptr;
                            post_cnt  <= '0;
                            auto_trig <= ~edge_hit;
                            state     <= POST;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                POST: begin
                    if (sample_valid) begin
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt == POST_LAST) begin
                            state         <= READY;
                            capture_ready <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (frame_done) begin
                        capture_ready <= 1'b0;
                        if (trig_mode == 2'd2 && !arm) begin
                            state <= IDLE;
                        end else begin
                            state      <= PREFILL;
                            pre_cnt    <= '0;
                            prev_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Self-checking bench for scope_trigger_capture: each scenario predicts the trigger
// position and frozen record from the presented sample stream.
module tb_scope_trigger_capture;

    localparam int PRE    = 32;
    localparam int DEPTH  = 256;
    localparam int AT     = 16;
    localparam int STIM_N = 2048;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = '0;
    logic [15:0] level = 16'd16384;
    logic        slope = 1'b0;
    logic [1:0]  tb_mode = 2'd1;
    logic        arm = 1'b0;
    logic        frame_done = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        capture_ready;
    logic        auto_trig;
    logic [2:0]  state_o;

    int total = 0;
    int bad   = 0;
    logic [15:0] stim [STIM_N];

    scope_trigger_capture #(
        .DW(16), .AW(8), .PRE(PRE), .AUTO_TIMEOUT(AT)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n),
        .sample_valid(sample_valid), .sample(sample),
        .trig_level(level), .trig_slope(slope), .trig_mode(tb_mode),
        .arm(arm), .frame_done(frame_done), .rd_addr(rd_addr),
        .rd_data(rd_data), .capture_ready(capture_ready),
        .auto_trig(auto_trig), .state_o(state_o)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Stream kinds: 0 ramp, 1 constant mid-scale, 2 square (period 20, starts low), 3 random table.
    function automatic logic [15:0] gen(input int kind, input int n);
        case (kind)
            0:       return 16'(n * 256);
            1:       return 16'h8000;
            2:       return ((n % 20) < 10) ? 16'h0000 : 16'hFFFF;
            default: return stim[n % STIM_N];
        endcase
    endfunction

    // Trigger index within the written stream: edges only count once the PRE prefill
    // samples are in; auto fires AT samples into the wait if no edge came first.
    function automatic void find_trig(input int kind, output int t, output bit au);
        logic [15:0] p, s;
        bit e;
        t = -1;
        au = 1'b0;
        for (int i = PRE; i < STIM_N - DEPTH; i++) begin
            p = gen(kind, i - 1);
            s = gen(kind, i);
            e = slope ? (p >= level && s < level) : (p < level && s >= level);
            if (e) begin
                t = i;
                return;
            end
            if (tb_mode == 2'd0 && (i - PRE) == AT - 1) begin
                t = i;
                au = 1'b1;
                return;
            end
        end
    endfunction

    task automatic rd(input int a, output logic [15:0] d);
        rd_addr = 8'(a);
        @(negedge CLOCK_50);
        d = rd_data;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sample_valid = 1'b0;
        frame_done = 1'b0;
        arm = 1'b0;
        #1;
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
        total++; if (capture_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", capture_ready); end
        total++; if (auto_trig !== 1'b0) begin bad++; $display("FAIL reset_auto: got %b want 0", auto_trig); end
        total++; if (rd_data !== 16'h8000) begin bad++; $display("FAIL reset_rd_data: got %h want 8000", rd_data); end
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic release_frame(input logic with_arm, input logic [2:0] exp_state);
        frame_done = 1'b1;
        arm = with_arm;
        @(negedge CLOCK_50);
        frame_done = 1'b0;
        arm = 1'b0;
        total++; if (capture_ready !== 1'b0) begin bad++; $display("FAIL release_ready: got %b want 0", capture_ready); end
        @(negedge CLOCK_50);
        total++; if (rd_data !== 16'h8000) begin bad++; $display("FAIL release_rd_data: got %h want 8000", rd_data); end
        total++; if (state_o !== exp_state) begin bad++; $display("FAIL release_state: got %0d want %0d", state_o, exp_state); end
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        @(negedge CLOCK_50);
        arm = 1'b0;
    endtask

    task automatic junk_samples(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            sample_valid = 1'b1;
            sample = 16'($urandom);
            @(negedge CLOCK_50);
        end
        sample_valid = 1'b0;
    endtask

    // Streams kind with one valid sample per vper cycles, then checks timing, auto flag and all 256 entries.
    task automatic capture(input int kind, input int vper);
        int t, n, cyc, budget;
        bit au, ok;
        logic [15:0] exp_v;
        find_trig(kind, t, au);
        n = 0; cyc = 0; ok = 1'b0;
        budget = (t + DEPTH) * vper + 50;
        while (cyc < budget) begin
            if (cyc % vper == 0) begin
                sample_valid = 1'b1;
                sample = gen(kind, n);
                n++;
            end else begin
                sample_valid = 1'b0;
            end
            @(negedge CLOCK_50);
            cyc++;
            if (capture_ready) begin
                ok = 1'b1;
                break;
            end
        end
        sample_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL capture_timeout: capture_ready=0 after %0d cycles, want 1", cyc);
            return;
        end
        total++; if (n !== t + DEPTH - PRE) begin bad++; $display("FAIL capture_latency: ready after %0d samples want %0d", n, t + DEPTH - PRE); end
        total++; if (auto_trig !== au) begin bad++; $display("FAIL auto_trig: got %b want %b", auto_trig, au); end
        rd_addr = '0;
        @(negedge CLOCK_50);
        for (int j = 0; j < DEPTH; j++) begin
            exp_v = gen(kind, t - PRE + j);
            total++;
            if (rd_data !== exp_v) begin
                bad++;
                $display("FAIL record[%0d]: got %0d want %0d", j, rd_data, exp_v);
            end
            rd_addr = 8'(j + 1);
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset();
        tb_mode = 2'd1; slope = 1'b0; level = 16'd16384;
        do_reset();
    endtask

    task automatic test_ramp();
        logic [15:0] d;
        capture(0, 1);
        rd(32, d);  total++; if (d !== 16'd16384) begin bad++; $display("FAIL ramp_idx32: got %0d want 16384", d); end
        rd(0, d);   total++; if (d !== 16'd8192)  begin bad++; $display("FAIL ramp_idx0: got %0d want 8192", d); end
        rd(255, d); total++; if (d !== 16'd7936)  begin bad++; $display("FAIL ramp_idx255: got %0d want 7936", d); end
    endtask

    task automatic test_valid_gaps();
        release_frame(1'b0, 3'd1);
        capture(0, 3);
    endtask

    task automatic test_square();
        logic [15:0] d;
        release_frame(1'b0, 3'd1);
        slope = 1'b1; level = 16'd32768;
        capture(2, 1);
        rd(32, d); total++; if (d !== 16'd0)     begin bad++; $display("FAIL square_idx32: got %0d want 0", d); end
        rd(31, d); total++; if (d !== 16'd65535) begin bad++; $display("FAIL square_idx31: got %0d want 65535", d); end
    endtask

    task automatic test_auto();
        tb_mode = 2'd0;
        release_frame(1'b0, 3'd1);
        slope = 1'b0; level = 16'd40000;
        capture(1, 1);
    endtask

    task automatic test_normal_hold();
        tb_mode = 2'd1;
        release_frame(1'b0, 3'd1);
        for (int i = 0; i < 300; i++) begin
            sample_valid = 1'b1;
            sample = gen(1, i);
            @(negedge CLOCK_50);
        end
        sample_valid = 1'b0;
        total++; if (capture_ready !== 1'b0) begin bad++; $display("FAIL normal_hold_ready: got %b want 0", capture_ready); end
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL normal_hold_state: got %0d want 2", state_o); end
    endtask

    task automatic test_random();
        int t;
        bit au;
        tb_mode = 2'd0;
        do_reset();
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < STIM_N; i++) stim[i] = 16'($urandom);
            level = 16'(16384 + $urandom_range(0, 32767));
            slope = 1'($urandom_range(0, 1));
            find_trig(3, t, au);
            if (t >= 0) begin
                capture(3, int'($urandom_range(1, 3)));
                tb_mode = (it % 2 == 0) ? 2'd1 : 2'd0;
                release_frame(1'b0, 3'd1);
            end else begin
                do_reset();
            end
        end
    endtask

    task automatic test_single();
        tb_mode = 2'd2; slope = 1'b0; level = 16'd16384;
        do_reset();
        junk_samples(5);
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL single_idle: got %0d want 0", state_o); end
        arm_pulse();
        capture(0, 1);
        release_frame(1'b0, 3'd0);
        junk_samples(7);
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL single_idle_after_frame: got %0d want 0", state_o); end
        slope = 1'b1; level = 16'd32768;
        arm_pulse();
        capture(2, 1);
        release_frame(1'b1, 3'd1);
        slope = 1'b0; level = 16'd16384;
        capture(0, 1);
        release_frame(1'b0, 3'd0);
    endtask

    task automatic test_reset_mid_post();
        tb_mode = 2'd1; slope = 1'b0; level = 16'd16384;
        do_reset();
        for (int n = 0; n < 70; n++) begin
            sample_valid = 1'b1;
            sample = gen(0, n);
            @(negedge CLOCK_50);
        end
        sample_valid = 1'b0;
        total++; if (state_o !== 3'd3) begin bad++; $display("FAIL mid_post_state: got %0d want 3", state_o); end
        do_reset();
        capture(0, 1);
        do_reset();
    endtask

    initial begin
        for (int i = 0; i < STIM_N; i++) stim[i] = '0;
        #5;
        test_reset();
        test_ramp();
        test_valid_gaps();
        test_square();
        test_auto();
        test_normal_hold();
        test_random();
        test_single();
        test_reset_mid_post();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scope_trigger_capture.md
Name: scope_trigger_capture

Overview:
- Upstream acquisition stage of the lab2 oscilloscope; sits between the 16-bit sample source and the VGA display stage.
- Watches the incoming sample stream for an edge crossing of a programmable level, with auto, normal and single-shot modes.
- Captures a DEPTH-sample record around the trigger point into a circular buffer, then freezes it.
- The display reads the frozen record by logical index (0 = oldest pre-trigger sample) and releases it with frame_done.

Parameters:
- DW, 16, sample width; offset binary, 32768 = 0 V.
- AW, 8, buffer address width; DEPTH = 2^AW = 256.
- PRE, 32, pre-trigger samples kept; legal range 1..DEPTH-2.
- AUTO_TIMEOUT, 65536, samples counted in WAIT_TRIG before auto mode forces a trigger.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  sample qualifier, one sample per asserted cycle.
- sample  in  DW  input sample.
- trig_level  in  DW  trigger threshold, offset binary.
- trig_slope  in  1  0 = rising edge, 1 = falling edge.
- trig_mode  in  2  0 = auto, 1 = normal, 2 = single; 3 is treated as normal.
- arm  in  1  single-shot arm pulse.
- frame_done  in  1  one-cycle pulse from display: record consumed.
- rd_addr  in  AW  logical read index.
- rd_data  out  DW  registered read data.
- capture_ready  out  1  frozen record available.
- auto_trig  out  1  last record was produced by the auto timeout.
- state_o  out  3  current FSM state, for debug.

Behaviour:
- Reset values: state IDLE; wr_ptr, pre_cnt, post_cnt, timeout counter, trig_ptr all 0; prev_valid 0; rd_data 16'h8000; capture_ready 0; auto_trig 0.
- State encoding: IDLE=0, PREFILL=1, WAIT_TRIG=2, POST=3, READY=4.
- Buffer write: in PREFILL, WAIT_TRIG and POST, each sample_valid cycle writes sample to mem[wr_ptr] and increments wr_ptr modulo DEPTH. No writes occur in IDLE or READY.
- IDLE:
  - Modes 0, 1 and 3: go to PREFILL on the next cycle.
  - Mode 2: wait for arm, then go to PREFILL.
  - On entering PREFILL, clear pre_cnt and prev_valid.
- PREFILL: count valid samples with pre_cnt. On the valid cycle where pre_cnt reaches PRE-1, go to WAIT_TRIG and clear the timeout counter.
- Trigger detection (WAIT_TRIG, sample_valid=1, prev_valid=1), unsigned compare:
  - Rising: prev < trig_level and sample >= trig_level.
  - Falling: prev >= trig_level and sample < trig_level.
  - prev and prev_valid update on every valid sample in PREFILL and WAIT_TRIG.
  - The first sample after arming can never trigger.
- On a trigger sample:
  - Set trig_ptr = wr_ptr (the sample is written there), clear post_cnt, go to POST.
  - auto_trig is set to 0.
- Auto timeout (mode 0 only): when the timeout counter reaches AUTO_TIMEOUT-1 on a valid sample with no edge, that sample is the trigger and auto_trig is set to 1. An edge on the same sample takes priority, giving auto_trig=0.
- POST:
  - Count valid samples. On the valid cycle writing post sample number DEPTH-PRE-1, go to READY.
  - capture_ready=1 from the next cycle onward.
- READY:
  - Buffer is frozen. Physical read address = (trig_ptr - PRE + rd_addr) mod DEPTH.
  - rd_data is registered: it reflects rd_addr from the previous cycle (1-cycle latency).
  - Logical index PRE is the trigger sample.
- Outside READY: rd_data is 16'h8000 (one cycle after leaving READY) and capture_ready is 0.
- READY exit on frame_done:
  - Modes 0, 1 and 3: go to PREFILL.
  - Mode 2: go to IDLE, or directly to PREFILL if arm is high in the same cycle.
  - capture_ready drops the cycle after frame_done.
- arm is ignored outside IDLE and outside the READY+frame_done case. frame_done is ignored outside READY.
- Mode changes:
  - trig_mode is sampled only at IDLE exit and READY exit, and for the auto timeout check in WAIT_TRIG.
  - trig_level and trig_slope are live.
- sample_valid=0 cycles: all counters and the FSM hold, except the IDLE->PREFILL and READY transitions.
- Reset asserted mid-capture: immediate return to reset values. The buffer is not cleared, but the old record is discarded because capture_ready=0.

Test Plan:
- Ramp input 0,256,512,... every cycle, level 16384, rising, mode 1, PRE 32 -> trigger at sample 16384. After 223 further samples capture_ready=1. rd_addr 32 returns 16384 one cycle later; rd_addr 0 returns 8192; rd_addr 255 returns 73472 mod 65536.
- Constant 32768 input, mode 0, AUTO_TIMEOUT 16 -> record completes with auto_trig=1. Same input in mode 1 -> stays in WAIT_TRIG indefinitely, capture_ready=0.
- Square wave 0/65535 with period 20, falling slope, level 32768 -> rd_data at index 32 is 0 and at index 31 is 65535. Input already below level at arming -> no trigger on the first sample.
- Mode 2: capture completes, then frame_done -> state IDLE and no writes occur. arm -> PREFILL. frame_done and arm in the same cycle -> direct to PREFILL.
- sample_valid toggling 1-of-3 cycles -> same record contents as the continuous case; capture_ready is delayed proportionally.
- reset_n low in POST -> state 0, capture_ready 0, rd_data 16'h8000 immediately. Release -> normal re-capture.
